store_trace_buffer: RTL and testbench

- Downstream monitor of the single-cycle MIPS `computer` data-memory store bus (memwrite, dataadr, writedata).
- Captures word-aligned stores that fall in a programmable address window into a FIFO.
- Presents the FIFO contents on a valid/ready drain port for a host/UART bridge or a self-checking bench.
- Replaces ad-hoc negedge RAM peeking with a cycle-accurate, ordered store log.

---
 rtl/store_trace_buffer.sv | 143 ++++++++++++++
 tb/tb_store_trace_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/store_trace_buffer.sv
// store_trace_buffer: logs word-aligned CPU stores that fall inside an address window into a
// first-word-fall-through FIFO. Define STORE_TRACE_TIMESTAMP_EN to tag entries with a cycle stamp.
module store_trace_buffer #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0040,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFC0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   memwrite,
    input  logic [31:0]            dataadr,
    input  logic [31:0]            writedata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_addr,
    output logic [31:0]            out_data,
`ifdef STORE_TRACE_TIMESTAMP_EN
    output logic [31:0]            out_stamp,
`endif
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   misalign,
    output logic [7:0]             drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
`ifdef STORE_TRACE_TIMESTAMP_EN
        logic [31:0] stamp;
`endif
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             wr_entry;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_nxt;
    logic               hit;
    logic               push_req;
    logic               pop;
    logic               full;
    logic               push;
    logic               drop;

`ifdef STORE_TRACE_TIMESTAMP_EN
    logic [31:0]        stamp_cnt;

    // Free-running capture clock; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stamp_cnt <= 32'd0;
        end else begin
            stamp_cnt <= stamp_cnt + 32'd1;
        end
    end
`endif

    // Window match and push/pop qualification; only registered state feeds the drain side.
    always_comb begin
        hit      = memwrite && ((dataadr & ADDR_MASK) == ADDR_BASE);
        push_req = hit && (dataadr[1:0] == 2'b00);
        pop      = out_valid && out_ready;
        full     = (count == CNT_W'(DEPTH));
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    always_comb begin
        wr_entry       = '0;
        wr_entry.addr  = dataadr;
        wr_entry.data  = writedata;
`ifdef STORE_TRACE_TIMESTAMP_EN
        wr_entry.stamp = stamp_cnt;
`endif
    end

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Entry storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
        end
    end

    // Sticky error reporting; the drop counter saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
            misalign <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            if (hit && (dataadr[1:0] != 2'b00)) begin
                misalign <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    // Head of queue is read straight from storage (first-word-fall-through).
    always_comb begin
        out_addr  = mem[rd_ptr].addr;
        out_data  = mem[rd_ptr].data;
`ifdef STORE_TRACE_TIMESTAMP_EN
        out_stamp = mem[rd_ptr].stamp;
`endif
    end

endmodule

// File: tb/tb_store_trace_buffer.sv
// Scoreboard bench for store_trace_buffer: a queue-based reference model predicts drained
// entries and status; a monitor checks the DUT every cycle against it.
module tb_store_trace_buffer;

    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0000_0040;
    localparam logic [31:0] MASK  = 32'hFFFF_FFC0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  count;
    logic        overflow;
    logic        misalign;
    logic [7:0]  drop_cnt;
`ifdef STORE_TRACE_TIMESTAMP_EN
    logic [31:0] out_stamp;
`endif

    store_trace_buffer #(.DEPTH(DEPTH), .ADDR_BASE(BASE), .ADDR_MASK(MASK)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
`ifdef STORE_TRACE_TIMESTAMP_EN
        .out_stamp (out_stamp),
`endif
        .count     (count),
        .overflow  (overflow),
        .misalign  (misalign),
        .drop_cnt  (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   checks = 0;
    int   errors = 0;
    ent_t exp_q[$];
    int   mcnt = 0, mdrop = 0;
    bit   movf = 0, mmis = 0;
    int   exp_cnt = 0, exp_drop = 0;
    bit   exp_ovf = 0, exp_mis = 0;
    bit   chk_en = 0, rst_cyc = 0, started = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances to the state expected after the next edge.
    task automatic cyc(input logic rn, input logic mw, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
        bit hit, pop;
        @(negedge clk);
        #1;
        reset     = rn;
        memwrite  = mw;
        dataadr   = a;
        writedata = d;
        out_ready = rdy;
        exp_cnt   = mcnt;
        exp_ovf   = movf;
        exp_mis   = mmis;
        exp_drop  = mdrop;
        rst_cyc   = !rn;
        chk_en    = started;
        if (!rn) begin
            exp_q.delete();
            mcnt    = 0;
            movf    = 0;
            mmis    = 0;
            mdrop   = 0;
            started = 1;
        end else begin
            hit = mw && ((a & MASK) == BASE);
            pop = (mcnt != 0) && rdy;
            if (hit && a[1:0] != 2'b00) begin
                mmis = 1;
            end else if (hit) begin
                if (mcnt < DEPTH || pop) begin
                    exp_q.push_back('{addr: a, data: d});
                    mcnt++;
                end else begin
                    movf = 1;
                    if (mdrop != 255) mdrop++;
                end
            end
            if (pop) mcnt--;
        end
    endtask

    // Monitor: status every cycle, head contents whenever a handshake is about to occur.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (chk_en) begin
                chk("count", 32'(count), 32'(exp_cnt));
                chk("out_valid", 32'(out_valid), 32'(exp_cnt != 0));
                chk("overflow", 32'(overflow), 32'(exp_ovf));
                chk("misalign", 32'(misalign), 32'(exp_mis));
                chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
                if (out_valid && out_ready && !rst_cyc) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pop actual=handshake required=empty at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_addr", out_addr, e.addr);
                        chk("out_data", out_data, e.data);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        reset     = 1'b0;
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
        out_ready = 1'b0;

        // Reset held with a live matching store: nothing must be captured.
        repeat (2) cyc(0, 1, 32'h54, 32'h58, 1);
        cyc(1, 0, 0, 0, 0);

        // Single store, then one drain beat.
        cyc(1, 1, 32'h54, 32'h58, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);

        // Window and alignment filtering.
        cyc(1, 1, 32'h100, 32'h1, 0);
        cyc(1, 1, 32'h55, 32'h2, 0);
        cyc(1, 1, 32'h40, 32'h3, 0);
        cyc(1, 0, 32'h44, 32'h4, 0);
        repeat (3) cyc(1, 0, 0, 0, 1);

        // Overflow by one, then drain in order.
        for (int i = 0; i < 9; i++) cyc(1, 1, 32'h40 + 32'(4 * i), 32'(i), 0);
        repeat (10) cyc(1, 0, 0, 0, 1);

        // Full with simultaneous push and pop, three passes to wrap pointers.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) cyc(1, 1, 32'h40 + 32'(4 * i), $urandom, 0);
            cyc(1, 1, 32'h44, 32'hA000 + 32'(r), 1);
            repeat (9) cyc(1, 0, 0, 0, 1);
        end

        // Reset mid-operation with a simultaneous store and pop.
        for (int i = 0; i < 5; i++) cyc(1, 1, 32'h60 + 32'(4 * i), 32'(100 + i), 0);
        cyc(0, 1, 32'h48, 32'hBEEF, 1);
        repeat (2) cyc(1, 0, 0, 0, 0);

        // Drop counter saturation.
        for (int i = 0; i < 8; i++) cyc(1, 1, 32'h40 + 32'(4 * i), 32'(i), 0);
        repeat (300) cyc(1, 1, 32'h7C, 32'hDEAD, 0);
        repeat (10) cyc(1, 0, 0, 0, 1);

        // Randomized traffic with alternating consumer pressure.
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'h40 + 32'(4 * $urandom_range(0, 15));
                1:       a = 32'h40 + 32'($urandom_range(0, 63));
                2:       a = $urandom;
                default: a = 32'($urandom_range(0, 255));
            endcase
            cyc(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)), a, $urandom,
                ((c / 64) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
        end

        repeat (DEPTH + 4) cyc(1, 0, 0, 0, 1);
        @(negedge clk);
        #3;
        chk("drained_all", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
